// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped write-through cache.
// Latency: n/a (types only).
// Backpressure: n/a.
package cache_pkg;

    typedef logic [7:0] word_t [0:3];

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        WRITE
    } cache_state_t;

endpackage

// File: rtl/dm_wt_cache_byte_merge.sv
// Per-lane byte merge of store data over a base word.
// Latency: combinational.
// Backpressure: none.
module byte_merge
    import cache_pkg::*;
(
    input  word_t      i_base,
    input  word_t      i_wdata,
    input  logic [3:0] i_be,
    output word_t      o_word
);

    // Enabled lanes take the store byte, others keep the base byte.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            o_word[k] = i_be[k] ? i_wdata[k] : i_base[k];
        end
    end

endmodule

// File: rtl/dm_wt_cache.sv
// Direct-mapped write-through write-allocate cache, one word per line.
// Latency: load hit 0 cycles; load miss and every store MEM_LATENCY cycles.
// Backpressure: cpu_ready low holds the request; requester keeps fields stable.
module dm_wt_cache
    import cache_pkg::*;
#(
    parameter int LINES       = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_addr,
    input  word_t       cpu_wdata,
    output word_t       cpu_rdata,
    output logic        cpu_ready,
    output logic [31:0] mem_addr,
    output word_t       mem_data_in,
    output logic        mem_we,
    input  word_t       mem_data_out
);

    localparam int         IDX_W    = $clog2(LINES);
    localparam int         TAG_W    = 30 - IDX_W;
    localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

    cache_state_t            r_state;
    cache_state_t            w_next_state;
    logic [2:0]              r_cnt;
    logic [2:0]              w_next_cnt;
    logic [LINES-1:0]        r_valid;
    logic [TAG_W-1:0]        r_tag [LINES];
    word_t                   r_data [LINES];

    logic [IDX_W-1:0]        w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic                    w_hit;
    word_t                   w_base;
    word_t                   w_merged;
    logic                    w_fill;
    word_t                   w_fill_data;

    assign w_idx = cpu_addr[2+IDX_W-1:2];
    assign w_tag = cpu_addr[31:2+IDX_W];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Memory is word-addressed; the byte offset is masked, not forwarded.
    assign mem_addr = {cpu_addr[31:2], cpu_addr[1:0] & 2'b00};

    // Merge base: the cached word on a hit, the memory word on a miss.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_base[k] = w_hit ? r_data[w_idx][k] : mem_data_out[k];
        end
    end

    byte_merge u_merge (
        .i_base  (w_base),
        .i_wdata (cpu_wdata),
        .i_be    (cpu_be),
        .o_word  (w_merged)
    );

    // Next state, countdown and all request/memory-side outputs.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        cpu_ready    = 1'b0;
        mem_we       = 1'b0;
        w_fill       = 1'b0;
        w_fill_data  = mem_data_out;
        for (int k = 0; k < 4; k++) begin
            cpu_rdata[k]   = 8'h00;
            mem_data_in[k] = 8'h00;
        end

        case (r_state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        w_next_state = WRITE;
                        w_next_cnt   = CNT_INIT;
                    end else if (w_hit) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = r_data[w_idx];
                    end else begin
                        w_next_state = MISS;
                        w_next_cnt   = CNT_INIT;
                    end
                end
            end
            MISS: begin
                if (r_cnt != 3'd0) begin
                    w_next_cnt = r_cnt - 3'd1;
                end else begin
                    cpu_ready    = 1'b1;
                    cpu_rdata    = mem_data_out;
                    w_fill       = 1'b1;
                    w_fill_data  = mem_data_out;
                    w_next_state = IDLE;
                end
            end
            WRITE: begin
                mem_data_in = w_merged;
                if (r_cnt != 3'd0) begin
                    w_next_cnt = r_cnt - 3'd1;
                end else begin
                    mem_we       = 1'b1;
                    cpu_ready    = 1'b1;
                    w_fill       = 1'b1;
                    w_fill_data  = w_merged;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Reset wins over a completing access: no strobe, no line update.
        if (rst) begin
            cpu_ready = 1'b0;
            mem_we    = 1'b0;
            w_fill    = 1'b0;
            for (int k = 0; k < 4; k++) begin
                cpu_rdata[k] = 8'h00;
            end
        end
    end

    // State, countdown and valid bits; reset invalidates every line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_valid <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_fill) begin
                r_valid[w_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays are left uninitialised; valid bits guard them.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= w_fill_data;
        end
    end

endmodule

// File: tb/tb_dm_wt_cache.sv
module tb_dm_wt_cache;
    import cache_pkg::*;

    localparam int LAT   = 4;
    localparam int LINES = 8;
    localparam int IDX_W = $clog2(LINES);
    localparam int BOUND = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, init_mem;
    logic        cpu_req, cpu_we, cpu_ready, mem_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr, mem_addr, wdata_p, rdata_p, mem_in_p, mem_word;
    word_t       cpu_wdata, cpu_rdata, mem_data_in, mem_data_out;

    logic        cpu_req1, cpu_we1, cpu_ready1, mem_we1;
    logic [3:0]  cpu_be1;
    logic [31:0] cpu_addr1, mem_addr1, wdata_p1, rdata_p1, mem_in_p1, mem_word1;
    word_t       cpu_wdata1, cpu_rdata1, mem_data_in1, mem_data_out1;

    int checks = 0;
    int errors = 0;

    dm_wt_cache #(.LINES(LINES), .MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_we(mem_we), .mem_data_out(mem_data_out)
    );

    dm_wt_cache #(.LINES(LINES), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_be(cpu_be1),
        .cpu_addr(cpu_addr1), .cpu_wdata(cpu_wdata1), .cpu_rdata(cpu_rdata1),
        .cpu_ready(cpu_ready1), .mem_addr(mem_addr1), .mem_data_in(mem_data_in1),
        .mem_we(mem_we1), .mem_data_out(mem_data_out1)
    );

    // Lane k of a word is byte k of its packed form.
    assign cpu_wdata[0] = wdata_p[7:0];
    assign cpu_wdata[1] = wdata_p[15:8];
    assign cpu_wdata[2] = wdata_p[23:16];
    assign cpu_wdata[3] = wdata_p[31:24];
    assign mem_data_out[0] = mem_word[7:0];
    assign mem_data_out[1] = mem_word[15:8];
    assign mem_data_out[2] = mem_word[23:16];
    assign mem_data_out[3] = mem_word[31:24];
    assign rdata_p  = {cpu_rdata[3], cpu_rdata[2], cpu_rdata[1], cpu_rdata[0]};
    assign mem_in_p = {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};

    assign cpu_wdata1[0] = wdata_p1[7:0];
    assign cpu_wdata1[1] = wdata_p1[15:8];
    assign cpu_wdata1[2] = wdata_p1[23:16];
    assign cpu_wdata1[3] = wdata_p1[31:24];
    assign mem_word1 = mem_addr1 ^ 32'h5EED_0000;
    assign mem_data_out1[0] = mem_word1[7:0];
    assign mem_data_out1[1] = mem_word1[15:8];
    assign mem_data_out1[2] = mem_word1[23:16];
    assign mem_data_out1[3] = mem_word1[31:24];
    assign rdata_p1  = {cpu_rdata1[3], cpu_rdata1[2], cpu_rdata1[1], cpu_rdata1[0]};
    assign mem_in_p1 = {mem_data_in1[3], mem_data_in1[2], mem_data_in1[1], mem_data_in1[0]};

    // Word memory behind the main instance (64 words covers every address used).
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= (32'(i) * 32'h0103_0507) ^ 32'hA5C3_0F1E;
            mem[16] <= 32'h4433_2211;
            mem[32] <= 32'h0403_0201;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_in_p;
        end
    end
    always_comb mem_word = mem[mem_addr[7:2]];

    // Requester must hold cpu_req until cpu_ready.
    logic pend = 1'b0;
    always @(posedge clk) begin
        if (pend && !rst) begin
            assert (cpu_req === 1'b1) else begin
                errors++;
                $error("FAIL protocol observed cpu_req=%b required=1", cpu_req);
            end
        end
        pend <= cpu_req && !cpu_ready && !rst;
    end

    // Reference model: line contents as the rules dictate.
    bit          mv   [LINES];
    logic [31:0] mtag [LINES];
    logic [31:0] mdat [LINES];

    function automatic logic [31:0] merge(logic [31:0] base, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r = base;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on the main instance, checked against the model.
    task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
        int          idx   = int'((addr >> 2) % LINES);
        logic [31:0] t     = addr >> (2 + IDX_W);
        bit          hit   = mv[idx] && (mtag[idx] == t);
        logic [31:0] memw  = mem[addr[7:2]];
        int          elat  = (hit && !we) ? 0 : LAT;
        logic [31:0] edata = we ? merge(hit ? mdat[idx] : memw, wd, be) : (hit ? mdat[idx] : memw);
        int          c     = 0;
        bit          early = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; wdata_p = wd;
        forever begin
            @(negedge clk);
            if (cpu_ready) break;
            if (mem_we) early = 1;
            if (c == BOUND) break;
            c++;
        end
        check({tag, ".ready"}, 32'(cpu_ready), 32'd1);
        check({tag, ".latency"}, 32'(c), 32'(elat));
        check({tag, ".early_we"}, 32'(early), 32'd0);
        if (we) begin
            check({tag, ".mem_we"}, 32'(mem_we), 32'd1);
            check({tag, ".mem_data_in"}, mem_in_p, edata);
        end else begin
            check({tag, ".rdata"}, rdata_p, edata);
            check({tag, ".mem_we_load"}, 32'(mem_we), 32'd0);
            check({tag, ".mem_in_load"}, mem_in_p, 32'd0);
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        mv[idx] = 1; mtag[idx] = t; mdat[idx] = edata;
    endtask

    initial begin
        bit saw_we;
        rst = 1'b1; init_mem = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_addr = 0; wdata_p = 0;
        cpu_req1 = 0; cpu_we1 = 0; cpu_be1 = 0; cpu_addr1 = 0; wdata_p1 = 0;
        for (int i = 0; i < LINES; i++) mv[i] = 0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; init_mem = 1'b0;

        @(negedge clk);
        check("reset.ready", 32'(cpu_ready), 32'd0);
        check("reset.mem_we", 32'(mem_we), 32'd0);
        check("reset.rdata", rdata_p, 32'd0);
        check("reset.mem_in", mem_in_p, 32'd0);
        @(posedge clk); #1;

        xact(1'b0, 4'h0, 32'h40, 32'h0, "load40_miss");
        check("load40_miss.value", mdat[0], 32'h4433_2211);
        xact(1'b0, 4'h0, 32'h40, 32'h0, "load40_hit");
        xact(1'b1, 4'b0101, 32'h40, 32'hDDCC_BBAA, "store40_hit");
        check("store40.value", mdat[0], 32'h44CC_22AA);
        xact(1'b0, 4'h0, 32'h40, 32'h0, "load40_after_store");
        xact(1'b1, 4'b1000, 32'h80, 32'hDDCC_BBAA, "store80_miss");
        check("store80.value", mdat[0], 32'hDD03_0201);
        xact(1'b0, 4'h0, 32'h80, 32'h0, "load80_hit");
        xact(1'b1, 4'b0000, 32'h84, 32'h1234_5678, "store84_be0");
        check("store84_be0.value", mdat[1], mem[33]);
        xact(1'b0, 4'h0, 32'h40, 32'h0, "conflict40");
        xact(1'b0, 4'h0, 32'h60, 32'h0, "conflict60");
        xact(1'b0, 4'h0, 32'h40, 32'h0, "conflict40_again");

        // Reset in cycle 2 of a store.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h40; wdata_p = 32'hFEED_BEEF;
        saw_we = 0;
        repeat (2) begin
            @(negedge clk); if (mem_we) saw_we = 1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.ready", 32'(cpu_ready), 32'd0);
        if (mem_we) saw_we = 1;
        @(posedge clk); #1;
        rst = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < LINES; i++) mv[i] = 0;
        repeat (6) begin
            @(negedge clk); if (mem_we) saw_we = 1;
        end
        check("rst_mid.no_we", 32'(saw_we), 32'd0);
        check("rst_mid.mem_kept", mem[16], 32'h44CC_22AA);
        @(posedge clk); #1;
        xact(1'b0, 4'h0, 32'h40, 32'h0, "after_rst_load40");

        // Random traffic over four tags per index.
        for (int n = 0; n < 300; n++) begin
            xact(1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom_range(0, 127)),
                 $urandom, "rand");
        end

        // Single-cycle-latency instance.
        cpu_req1 = 1'b1; cpu_we1 = 1'b0; cpu_addr1 = 32'h40;
        @(negedge clk);
        check("lat1.load_c0_ready", 32'(cpu_ready1), 32'd0);
        @(negedge clk);
        check("lat1.load_c1_ready", 32'(cpu_ready1), 32'd1);
        check("lat1.load_data", rdata_p1, 32'h40 ^ 32'h5EED_0000);
        @(posedge clk); #1;
        cpu_we1 = 1'b1; cpu_be1 = 4'b0011; cpu_addr1 = 32'h44; wdata_p1 = 32'h1234_5678;
        @(negedge clk);
        check("lat1.store_c0_ready", 32'(cpu_ready1), 32'd0);
        check("lat1.store_c0_we", 32'(mem_we1), 32'd0);
        @(negedge clk);
        check("lat1.store_c1_ready", 32'(cpu_ready1), 32'd1);
        check("lat1.store_c1_we", 32'(mem_we1), 32'd1);
        check("lat1.store_data", mem_in_p1, merge(32'h44 ^ 32'h5EED_0000, 32'h1234_5678, 4'b0011));
        @(posedge clk); #1;
        cpu_we1 = 1'b0; cpu_be1 = 4'h0;
        @(negedge clk);
        check("lat1.we_width", 32'(mem_we1), 32'd0);
        check("lat1.load_hit_ready", 32'(cpu_ready1), 32'd1);
        check("lat1.load_hit_data", rdata_p1, merge(32'h44 ^ 32'h5EED_0000, 32'h1234_5678, 4'b0011));
        @(posedge clk); #1;
        cpu_req1 = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_wt_cache.md
# dm_wt_cache

Direct-mapped, write-through, write-allocate cache between the processor's load/store path and the word-addressable `memory` block. Read hits complete in the request cycle. Misses and all stores are held for a fixed memory latency. Every store becomes a whole-word write to memory: byte-enabled stores are merged with the current word (read-modify-write), because `memory` only writes full 4-byte words.

## Interface
Parameters:
- `LINES`, 8: number of one-word lines; power of two, ≥2; `IDX_W = $clog2(LINES)`.
- `MEM_LATENCY`, 4: cycles a memory access occupies; ≥1.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  request valid; held with all request fields stable until `cpu_ready`.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_be`  in  4  byte enables, bit k selects byte lane k; ignored for loads.
- `cpu_addr`  in  32  byte address; bits [1:0] ignored.
- `cpu_wdata`  in  4×8 (`[7:0] [0:3]`)  store data, lane k = byte k.
- `cpu_rdata`  out  4×8  load data; valid only while `cpu_ready && !cpu_we`.
- `cpu_ready`  out  1  request completes this cycle.
- `mem_addr`  out  32  `{cpu_addr[31:2], 2'b00}`, driven continuously.
- `mem_data_in`  out  4×8  merged store word.
- `mem_we`  out  1  one-cycle memory write strobe.
- `mem_data_out`  in  4×8  combinational read data from `memory`.

## Operation
- Address split:
  - index = `cpu_addr[2+IDX_W-1:2]`
  - tag = `cpu_addr[31:2+IDX_W]`
  - hit = `valid[index] && tag_ram[index] == tag`
- State machine, states `IDLE`, `MISS`, `WRITE`; 3-bit down-counter `cnt`:
  - `IDLE`, no request: stay.
  - `IDLE`, load hit: `cpu_ready=1`, `cpu_rdata = data_ram[index]`; stay.
  - `IDLE`, load miss: `cnt <= MEM_LATENCY-1`, go `MISS`.
  - `IDLE`, store (hit or miss): `cnt <= MEM_LATENCY-1`, go `WRITE`.
  - `MISS`, `cnt != 0`: decrement.
  - `MISS`, `cnt == 0`: `cpu_ready=1`, `cpu_rdata = mem_data_out`; line filled (valid, tag, data); go `IDLE`.
  - `WRITE`, `cnt != 0`: decrement.
  - `WRITE`, `cnt == 0`: `mem_we=1`, `cpu_ready=1`; line written with merged word, valid set, tag set; go `IDLE`.
- Merge rule, per lane k: `cpu_be[k] ? cpu_wdata[k] : base[k]`.
  - `base` = `data_ram[index]` on hit, `mem_data_out` on miss.
  - `cpu_be = 4'b0000` still performs the write cycle; the word is unchanged.
- Memory-side outputs:
  - `mem_data_in` is the merged word whenever the state is `WRITE`, 0 otherwise.
  - `mem_we` is high only in the completing `WRITE` cycle.
- The cache never evicts dirty data; write-through means no dirty bits.

## Timing
- Reset values:
  - state `IDLE`, `cnt=0`, all `valid=0`.
  - `cpu_ready=0`, `mem_we=0`, `cpu_rdata=0`, `mem_data_in=0`.
  - tag/data RAMs are not cleared.
- Request accepted in cycle 0 (`cpu_req=1` in `IDLE`):
  - Load hit: `cpu_ready` in cycle 0, zero added latency.
  - Load miss and every store: `cpu_ready` in cycle `MEM_LATENCY`; `MEM_LATENCY=1` gives ready in cycle 1.
- Back-to-back: the next request may be presented in the cycle after `cpu_ready`. A load to the just-filled or just-written line then hits.
- Reset during `MISS` or `WRITE`:
  - Takes priority; no `mem_we` in the reset cycle, no line update.
  - Returns to `IDLE` with all lines invalid.
- Deasserting `cpu_req` before `cpu_ready` is a protocol violation. Assertion in bench; RTL behaviour undefined.
- A load following a store to the same index with a different tag misses and replaces the line.

## Structure
- `cache_pkg` holds:
  - `typedef logic [7:0] word_t [0:3]`
  - `typedef enum logic [1:0] {IDLE, MISS, WRITE} cache_state_t`
- One natural sub-module: `byte_merge`, combinational, taking `base`, `wdata`, `be` and producing the merged `word_t`.
- The tag/valid/data arrays are inline registers.

## Test plan
- Reset, then load `0x40` → miss; `mem_data_out={11,22,33,44}` presented; `cpu_ready` in cycle 4 with that data; repeat load `0x40` → ready in cycle 0, same data.
- Store `0x40`, `be=4'b0101`, `wdata={AA,BB,CC,DD}`, line holds `{11,22,33,44}` → `mem_we` pulse in cycle 4 with `mem_data_in={AA,22,CC,44}`; subsequent load hits returning `{AA,22,CC,44}`.
- Store miss to `0x80`, `be=4'b1000`, memory word `{01,02,03,04}` → writes `{01,02,03,DD}`, line allocated; next load `0x80` hits.
- Conflict: load `0x40` then load `0x60` (LINES=8, same index 0) → both miss; reload `0x40` misses again.
- Assert `rst` in cycle 2 of a store → `mem_we` never asserts; afterwards load `0x40` misses.
- `MEM_LATENCY=1` build: load miss and store each complete in cycle 1; `mem_we` exactly one cycle wide.
